// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared FSM encoding and default watchdog limit for wb_arbiter
// Contents:
//   WB_ARB_TIMEOUT_DEFAULT  default wait budget for an owner before abort
//   arb_state_t             arbiter FSM state encoding
package wb_arbiter_pkg;

   localparam int WB_ARB_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN0  = 2'd1,
      ST_OWN1  = 2'd2,
      ST_ABORT = 2'd3
   } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - saturating wait-cycle counter with terminal-count detect
// Ports:
//   i_clk, i_resetn  clock, asynchronous active-low reset
//   i_clear          zero the counter (wins over i_count_en)
//   i_count_en       this cycle is a wait cycle
//   o_expired        this wait cycle brings the count to TERMINAL
module wb_arb_watchdog #(
   parameter  int TERMINAL = 255,
   localparam int W        = $clog2(TERMINAL + 1)
) (
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_clear,
   input  logic i_count_en,
   output logic o_expired
);

   localparam logic [W-1:0] LIMIT = W'(TERMINAL);
   localparam logic [W-1:0] LAST  = W'(TERMINAL - 1);

   logic [W-1:0] count;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         count <= '0;
      end else if (i_clear) begin
         count <= '0;
      end else if (i_count_en && (count != LIMIT)) begin
         count <= count + W'(1);
      end
   end

   // Flag the wait cycle that completes the budget so the abort lands on
   // that edge rather than one cycle later.
   assign o_expired = i_count_en && !i_clear && (count == LAST);

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master Wishbone arbiter, round-robin with watchdog abort
// Ports:
//   i_clk, i_resetn             clock, asynchronous active-low reset
//   i_mN_wb_*                   master N request (cyc, stb, we, addr, data, sel)
//   o_mN_wb_*                   master N response (ack, stall, err, data)
//   o_wb_*                      shared slave-side request
//   i_wb_*                      slave response (ack, stall, err, data)
//   o_grant                     one-hot current owner, 0 when idle
//   o_timeout                   one-cycle pulse when the watchdog aborts a transfer
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = WB_ARB_TIMEOUT_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_m0_wb_cyc,
   input  logic        i_m0_wb_stb,
   input  logic        i_m0_wb_we,
   input  logic [31:0] i_m0_wb_addr,
   input  logic [31:0] i_m0_wb_data,
   input  logic [3:0]  i_m0_wb_sel,
   output logic        o_m0_wb_ack,
   output logic        o_m0_wb_stall,
   output logic        o_m0_wb_err,
   output logic [31:0] o_m0_wb_data,
   input  logic        i_m1_wb_cyc,
   input  logic        i_m1_wb_stb,
   input  logic        i_m1_wb_we,
   input  logic [31:0] i_m1_wb_addr,
   input  logic [31:0] i_m1_wb_data,
   input  logic [3:0]  i_m1_wb_sel,
   output logic        o_m1_wb_ack,
   output logic        o_m1_wb_stall,
   output logic        o_m1_wb_err,
   output logic [31:0] o_m1_wb_data,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic        i_wb_err,
   input  logic [31:0] i_wb_data,
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   arb_state_t state;
   logic       owner;        // index of the master holding OWNx or ABORT
   logic       last_owner;   // most recent releaser, loses the next tie
   logic       abort_pulse;  // high only in the first ABORT cycle
   logic [1:0] grant_q;

   logic own0, own1, owning, owner_cyc;
   logic wd_clear, wd_en, wd_expired;

   assign own0      = (state == ST_OWN0);
   assign own1      = (state == ST_OWN1);
   assign owning    = own0 | own1;
   assign owner_cyc = owner ? i_m1_wb_cyc : i_m0_wb_cyc;

   // A wait cycle is an owned cycle with the bus active and no slave reply.
   assign wd_clear = ~owning | i_wb_ack | i_wb_err;
   assign wd_en    = owning & owner_cyc & ~i_wb_ack & ~i_wb_err;

   wb_arb_watchdog #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk      (i_clk),
      .i_resetn   (i_resetn),
      .i_clear    (wd_clear),
      .i_count_en (wd_en),
      .o_expired  (wd_expired)
   );

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state       <= ST_IDLE;
         owner       <= 1'b0;
         last_owner  <= 1'b1;
         abort_pulse <= 1'b0;
         grant_q     <= 2'b00;
      end else begin
         abort_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               // m0 wins unless m1 also asks and m0 held the bus last.
               if (i_m0_wb_cyc && (!i_m1_wb_cyc || last_owner)) begin
                  state   <= ST_OWN0;
                  owner   <= 1'b0;
                  grant_q <= 2'b01;
               end else if (i_m1_wb_cyc) begin
                  state   <= ST_OWN1;
                  owner   <= 1'b1;
                  grant_q <= 2'b10;
               end
            end
            ST_OWN0, ST_OWN1: begin
               // Release is checked first so a drop on the terminal cycle
               // never produces an abort.
               if (!owner_cyc) begin
                  state      <= ST_IDLE;
                  last_owner <= owner;
                  grant_q    <= 2'b00;
               end else if (wd_expired) begin
                  state       <= ST_ABORT;
                  abort_pulse <= 1'b1;
               end
            end
            ST_ABORT: begin
               if (!owner_cyc) begin
                  state      <= ST_IDLE;
                  last_owner <= owner;
                  grant_q    <= 2'b00;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_grant   = grant_q;
   assign o_timeout = abort_pulse;

   assign o_wb_cyc  = own0 ? i_m0_wb_cyc  : own1 ? i_m1_wb_cyc  : 1'b0;
   assign o_wb_stb  = own0 ? i_m0_wb_stb  : own1 ? i_m1_wb_stb  : 1'b0;
   assign o_wb_we   = own0 ? i_m0_wb_we   : own1 ? i_m1_wb_we   : 1'b0;
   assign o_wb_addr = own0 ? i_m0_wb_addr : own1 ? i_m1_wb_addr : 32'h0;
   assign o_wb_data = own0 ? i_m0_wb_data : own1 ? i_m1_wb_data : 32'h0;
   assign o_wb_sel  = own0 ? i_m0_wb_sel  : own1 ? i_m1_wb_sel  : 4'h0;

   assign o_m0_wb_ack   = own0 & i_wb_ack;
   assign o_m0_wb_stall = own0 ? i_wb_stall : 1'b1;
   assign o_m0_wb_err   = (own0 & i_wb_err) | (abort_pulse & ~owner);
   assign o_m0_wb_data  = own0 ? i_wb_data : 32'h0;

   assign o_m1_wb_ack   = own1 & i_wb_ack;
   assign o_m1_wb_stall = own1 ? i_wb_stall : 1'b1;
   assign o_m1_wb_err   = (own1 & i_wb_err) | (abort_pulse & owner);
   assign o_m1_wb_data  = own1 ? i_wb_data : 32'h0;

endmodule
